// File: rtl/grf_wb_arbiter.sv
// Shares the GRF write port between the W stage (priority) and a buffered mult/div result path.
// Tracks pending destinations, squashes WAW-dead results and requests a stall on starvation.
module grf_wb_arbiter #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_we,
   input  logic [4:0]  p_a3,
   input  logic [31:0] p_wd,
   input  logic [31:0] p_pc,
   input  logic        m_valid,
   output logic        m_ready,
   input  logic [4:0]  m_a3,
   input  logic [31:0] m_wd,
   input  logic [31:0] m_pc,
   output logic        grf_we,
   output logic [4:0]  grf_a3,
   output logic [31:0] grf_wd,
   output logic [31:0] grf_wpc,
   output logic [31:0] busy,
   output logic        stall_req,
   output logic        proto_err,
   output logic [7:0]  squash_cnt
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    a3_q [DEPTH];
   logic [31:0]   wd_q [DEPTH];
   logic [31:0]   pc_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic          stall_q, stall_d;
   logic          perr_q, perr_d;
   logic [7:0]    squash_q, squash_d;
   logic [31:0]   busy_q, busy_d;

   logic [AW-1:0] ridx, widx;
   logic          empty, full, head_live, accept, push, pop;
   logic [7:0]    sq_n;
   logic [8:0]    sq_tot;
   logic [4:0]    slot_a3;

   // Write-port mux, FIFO bookkeeping, squash and starvation logic
   always_comb begin
      ridx      = rptr_q[AW-1:0];
      widx      = wptr_q[AW-1:0];
      empty     = (wptr_q == rptr_q);
      full      = ((wptr_q - rptr_q) == (AW+1)'(DEPTH));
      head_live = !empty && vld_q[ridx];
      m_ready   = !reset && !full;
      accept    = m_valid && m_ready;
      push      = accept && (m_a3 != 5'd0);
      // A squashed head retires even under a P write
      pop       = !reset && !empty && (!vld_q[ridx] || !p_we);

      grf_we  = 1'b0;
      grf_a3  = 5'd0;
      grf_wd  = 32'd0;
      grf_wpc = 32'd0;
      if (!reset) begin
         if (p_we) begin
            grf_we  = 1'b1;
            grf_a3  = p_a3;
            grf_wd  = p_wd;
            grf_wpc = p_pc;
         end else if (head_live) begin
            grf_we  = 1'b1;
            grf_a3  = a3_q[ridx];
            grf_wd  = wd_q[ridx];
            grf_wpc = pc_q[ridx];
         end
      end

      vld_d = vld_q;
      sq_n  = 8'd0;
      if (p_we && (p_a3 != 5'd0)) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld_q[i] && (a3_q[i] == p_a3)) begin
               vld_d[i] = 1'b0;
               sq_n     = sq_n + 8'd1;
            end
         end
      end
      if (pop)  vld_d[ridx] = 1'b0;
      if (push) vld_d[widx] = 1'b1;

      busy_d  = 32'd0;
      slot_a3 = 5'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         slot_a3 = (push && (AW'(i) == widx)) ? m_a3 : a3_q[i];
         if (vld_d[i]) busy_d[slot_a3] = 1'b1;
      end

      sq_tot   = {1'b0, squash_q} + 9'(sq_n);
      squash_d = sq_tot[8] ? 8'hFF : sq_tot[7:0];

      wptr_d = wptr_q + (AW+1)'(push);
      rptr_d = rptr_q + (AW+1)'(pop);

      cnt_d = cnt_q;
      if (empty || pop)
         cnt_d = '0;
      else if (head_live && p_we && (cnt_q != SW'(STARVE_LIMIT)))
         cnt_d = cnt_q + SW'(1);
      stall_d = !(empty || pop) && (cnt_d == SW'(STARVE_LIMIT));
      perr_d  = perr_q || (p_we && stall_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         stall_q  <= 1'b0;
         perr_q   <= 1'b0;
         squash_q <= 8'd0;
         busy_q   <= 32'd0;
      end else begin
         vld_q    <= vld_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         stall_q  <= stall_d;
         perr_q   <= perr_d;
         squash_q <= squash_d;
         busy_q   <= busy_d;
      end
   end

   // Payload storage needs no reset; validity lives in vld_q
   always_ff @(posedge clk) begin
      if (push) begin
         a3_q[widx] <= m_a3;
         wd_q[widx] <= m_wd;
         pc_q[widx] <= m_pc;
      end
   end

   assign busy       = reset ? 32'd0 : busy_q;
   assign stall_req  = stall_q;
   assign proto_err  = perr_q;
   assign squash_cnt = squash_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: expected M-path GRF writes are queued at stimulus time
// and retired by a write-port monitor; control/status outputs are checked inline.
module tb_grf_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_we;
   logic [4:0]  p_a3;
   logic [31:0] p_wd, p_pc;
   logic        m_valid, m_ready;
   logic [4:0]  m_a3;
   logic [31:0] m_wd, m_pc;
   logic        grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd, grf_wpc, busy;
   logic        stall_req, proto_err;
   logic [7:0]  squash_cnt;

   typedef struct packed {
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] pc;
   } wr_t;

   wr_t sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   grf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
      .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
      .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_wpc(grf_wpc),
      .busy(busy), .stall_req(stall_req), .proto_err(proto_err), .squash_cnt(squash_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_drive(input logic v, input logic [4:0] a3, input logic [31:0] wd,
                          input logic [31:0] pc);
      m_valid = v;
      m_a3    = a3;
      m_wd    = wd;
      m_pc    = pc;
   endtask

   task automatic p_drive(input logic we, input logic [4:0] a3);
      p_we = we;
      p_a3 = a3;
      p_wd = 32'hA000_0000 | 32'(a3);
      p_pc = 32'h0000_4000 + 32'(a3);
   endtask

   // Every GRF write is either the P write in flight or the oldest expected M result
   always @(negedge clk) begin
      if (!reset && grf_we === 1'b1) begin
         if (p_we) begin
            check("p_a3", 32'(grf_a3), 32'(p_a3));
            check("p_wd", grf_wd, p_wd);
            check("p_pc", grf_wpc, p_pc);
         end else begin
            n_tests++;
            assert (sb.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_m_write: observed a3=%0d wd=%0h expected no write",
                      grf_a3, grf_wd);
            end
            if (sb.size() != 0) begin
               wr_t e;
               e = sb.pop_front();
               check("m_a3", 32'(grf_a3), 32'(e.a3));
               check("m_wd", grf_wd, e.wd);
               check("m_pc", grf_wpc, e.pc);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      p_drive(1'b1, 5'd8);
      m_drive(1'b1, 5'd2, 32'hBAD0_0002, 32'h0);
      tick();
      @(negedge clk);
      check("rst_m_ready", 32'(m_ready), 32'd0);
      check("rst_grf_we", 32'(grf_we), 32'd0);
      check("rst_busy", busy, 32'd0);
      tick();

      reset = 1'b0;
      p_drive(1'b0, 5'd0);
      m_drive(1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("init_stall", 32'(stall_req), 32'd0);
      check("init_perr", 32'(proto_err), 32'd0);
      check("init_squash", 32'(squash_cnt), 32'd0);
      check("init_busy", busy, 32'd0);
      check("init_m_ready", 32'(m_ready), 32'd1);
      check("init_grf_we", 32'(grf_we), 32'd0);
      tick();

      // 1: single result, one-cycle latency, busy for exactly that cycle
      m_drive(1'b1, 5'd5, 32'h1234_5678, 32'h0000_3000);
      sb.push_back('{a3: 5'd5, wd: 32'h1234_5678, pc: 32'h0000_3000});
      @(negedge clk);
      check("t1_no_bypass", 32'(grf_we), 32'd0);
      check("t1_busy_n", busy, 32'd0);
      tick();
      m_drive(1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("t1_grf_we", 32'(grf_we), 32'd1);
      check("t1_busy_n1", busy, 32'h0000_0020);
      tick();
      @(negedge clk);
      check("t1_busy_n2", busy, 32'd0);
      check("t1_idle", 32'(grf_we), 32'd0);
      tick();

      // 2: starvation under continuous P writes
      p_drive(1'b1, 5'd8);
      m_drive(1'b1, 5'd9, 32'h0000_0099, 32'h0000_3100);
      sb.push_back('{a3: 5'd9, wd: 32'h0000_0099, pc: 32'h0000_3100});
      @(negedge clk);
      check("t2_stall_a", 32'(stall_req), 32'd0);
      tick();
      m_drive(1'b0, 5'd0, 32'd0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t2_stall_blk", 32'(stall_req), 32'd0);
         check("t2_busy9", busy, 32'h0000_0200);
         tick();
      end
      check("t2_stall_up", 32'(stall_req), 32'd1);
      p_drive(1'b0, 5'd0);
      @(negedge clk);
      check("t2_m_write", 32'(grf_a3), 32'd9);
      tick();
      check("t2_stall_clr", 32'(stall_req), 32'd0);
      check("t2_perr", 32'(proto_err), 32'd0);
      @(negedge clk);
      check("t2_busy_clr", busy, 32'd0);
      tick();

      // 3: fill FIFO, back-pressure, then drain and accept the held result
      p_drive(1'b1, 5'd8);
      m_drive(1'b1, 5'd3, 32'h0000_0033, 32'h0000_3300);
      @(negedge clk);
      check("t3_rdy0", 32'(m_ready), 32'd1);
      sb.push_back('{a3: 5'd3, wd: 32'h0000_0033, pc: 32'h0000_3300});
      tick();
      m_drive(1'b1, 5'd4, 32'h0000_0044, 32'h0000_3400);
      @(negedge clk);
      check("t3_rdy1", 32'(m_ready), 32'd1);
      sb.push_back('{a3: 5'd4, wd: 32'h0000_0044, pc: 32'h0000_3400});
      tick();
      m_drive(1'b1, 5'd6, 32'h0000_0066, 32'h0000_3600);
      @(negedge clk);
      check("t3_full", 32'(m_ready), 32'd0);
      check("t3_busy34", busy, 32'h0000_0018);
      tick();
      @(negedge clk);
      check("t3_full_hold", 32'(m_ready), 32'd0);
      tick();
      p_drive(1'b0, 5'd0);
      @(negedge clk);
      check("t3_no_same_pop", 32'(m_ready), 32'd0);
      check("t3_wr3", 32'(grf_a3), 32'd3);
      check("t3_stall", 32'(stall_req), 32'd0);
      tick();
      @(negedge clk);
      check("t3_rdy_rise", 32'(m_ready), 32'd1);
      check("t3_wr4", 32'(grf_a3), 32'd4);
      sb.push_back('{a3: 5'd6, wd: 32'h0000_0066, pc: 32'h0000_3600});
      tick();
      m_drive(1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("t3_wr6", 32'(grf_a3), 32'd6);
      tick();

      // 4: WAW squash of a buffered result
      p_drive(1'b1, 5'd8);
      m_drive(1'b1, 5'd7, 32'h0000_0077, 32'h0000_3700);
      tick();
      m_drive(1'b0, 5'd0, 32'd0, 32'd0);
      p_drive(1'b1, 5'd7);
      @(negedge clk);
      check("t4_busy7", busy, 32'h0000_0080);
      tick();
      p_drive(1'b0, 5'd0);
      @(negedge clk);
      check("t4_squash", 32'(squash_cnt), 32'd1);
      check("t4_busy_clr", busy, 32'd0);
      check("t4_no_write", 32'(grf_we), 32'd0);
      tick();
      @(negedge clk);
      check("t4_no_write2", 32'(grf_we), 32'd0);
      tick();

      // 5: result to $0 is accepted and dropped
      m_drive(1'b1, 5'd0, 32'hDEAD_BEEF, 32'h0000_3800);
      @(negedge clk);
      check("t5_rdy", 32'(m_ready), 32'd1);
      tick();
      m_drive(1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("t5_busy", busy, 32'd0);
      check("t5_no_write", 32'(grf_we), 32'd0);
      tick();

      // 6: reset with two results buffered
      p_drive(1'b1, 5'd8);
      m_drive(1'b1, 5'd10, 32'h0000_00AA, 32'h0000_3A00);
      tick();
      m_drive(1'b1, 5'd11, 32'h0000_00BB, 32'h0000_3B00);
      tick();
      m_drive(1'b0, 5'd0, 32'd0, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_busy", busy, 32'd0);
      check("t6_rst_we", 32'(grf_we), 32'd0);
      check("t6_rst_rdy", 32'(m_ready), 32'd0);
      tick();
      reset = 1'b0;
      p_drive(1'b0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_no_stale", 32'(grf_we), 32'd0);
         check("t6_busy", busy, 32'd0);
         tick();
      end
      check("t6_squash_rst", 32'(squash_cnt), 32'd0);

      // 7: P write during stall sets sticky proto_err; P still wins
      p_drive(1'b1, 5'd8);
      m_drive(1'b1, 5'd12, 32'h0000_00CC, 32'h0000_3C00);
      sb.push_back('{a3: 5'd12, wd: 32'h0000_00CC, pc: 32'h0000_3C00});
      tick();
      m_drive(1'b0, 5'd0, 32'd0, 32'd0);
      repeat (4) tick();
      check("t7_stall", 32'(stall_req), 32'd1);
      @(negedge clk);
      check("t7_p_wins", 32'(grf_a3), 32'd8);
      tick();
      check("t7_perr", 32'(proto_err), 32'd1);
      check("t7_stall_hold", 32'(stall_req), 32'd1);
      p_drive(1'b0, 5'd0);
      @(negedge clk);
      check("t7_m_write", 32'(grf_a3), 32'd12);
      tick();
      check("t7_stall_clr", 32'(stall_req), 32'd0);
      check("t7_perr_sticky", 32'(proto_err), 32'd1);
      repeat (2) tick();

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the single GRF write port (A3/WD/WE/WPC) between two requesters:
  - the in-order pipeline W stage (port P), which always has priority and cannot be back-pressured;
  - the multi-cycle mult/div unit result path (port M), which uses a valid/ready handshake.
- M results are buffered in a small FIFO and drained into idle write-port cycles.
- Provides a pending-register busy vector for the hazard unit.
- Raises a stall request when an M result starves.

Parameters:
- DEPTH, 2: M-result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 4: consecutive cycles a FIFO head may be blocked by P before stall_req asserts (≥1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- p_we  in  1  W-stage write enable.
- p_a3  in  5  W-stage destination register.
- p_wd  in  32  W-stage write data.
- p_pc  in  32  W-stage PC.
- m_valid  in  1  mult/div result valid.
- m_ready  out  1  FIFO can accept.
- m_a3  in  5  result destination register.
- m_wd  in  32  result data.
- m_pc  in  32  PC of the originating instruction.
- grf_we  out  1  to GRF WE.
- grf_a3  out  5  to GRF A3.
- grf_wd  out  32  to GRF WD.
- grf_wpc  out  32  to GRF WPC.
- busy  out  32  bit r = 1 if any valid FIFO entry targets register r.
- stall_req  out  1  registered; pipeline must insert a W bubble (p_we=0) while high.
- proto_err  out  1  sticky; p_we=1 seen while stall_req=1.
- squash_cnt  out  8  saturating count of WAW-squashed FIFO entries.

Behaviour:
- Reset (synchronous): FIFO emptied, all entries invalid, starve counter=0, stall_req=0, proto_err=0, squash_cnt=0.
  - During reset: m_ready=0, grf_we=0, busy=0.
  - Reset mid-operation discards buffered results silently.
- Write-port mux (combinational, same cycle):
  - p_we=1: grf_* = p_*.
  - Else if FIFO non-empty: grf_* = head fields, grf_we=1, head popped at posedge.
  - Else grf_we=0, grf_a3=0, grf_wd=0, grf_wpc=0.
- m_ready = !full (not dependent on same-cycle pop).
  - Accept when m_valid & m_ready; the entry is pushed at posedge.
  - Minimum accept-to-GRF-write latency: 1 cycle. No same-cycle bypass.
- m_a3=0: still accepted (m_ready rules apply), but discarded, never enqueued, never sets busy.
- FIFO order is strict: entries drain oldest first, one per free cycle.
- WAW squash: when p_we=1 and p_a3≠0 matches the a3 of valid FIFO entries:
  - all matching entries are invalidated at posedge;
  - squash_cnt += number squashed (saturates at 255).
  - Invalidated entries occupy FIFO slots until they reach the head, then pop without writing. The pop takes a cycle; grf_we follows P only.
  - A squashed head pops even when p_we=1.
  - An entry accepted in the same cycle is not checked against that cycle's P write.
- busy: OR over valid entries of the one-hot of a3. Updated at posedge; a freshly accepted entry shows in busy the next cycle.
- Starve counter:
  - Increments each cycle a valid head exists and p_we=1.
  - Clears on head pop or when the FIFO is empty.
  - When it reaches STARVE_LIMIT, stall_req=1 from the next cycle.
  - stall_req clears the cycle after the blocked head is written.
- p_we=1 while stall_req=1: P still wins the port, proto_err is set (sticky until reset), and the counter holds.
- Full and m_valid=1: m_ready=0; the producer holds its data. No loss.

Test Plan:
1. Reset, FIFO empty, p_we=0. Push M {a3=5, wd=0x12345678, pc=0x3000}. Cycle N accept → cycle N+1: grf_we=1, grf_a3=5, grf_wd=0x12345678; busy[5]=1 during N+1 only.
2. Continuous p_we=1 (a3=8). Push M a3=9. Starve counter reaches 4 → stall_req=1 next cycle. Bench drops p_we → M write to $9 happens → stall_req=0 the following cycle. proto_err stays 0.
3. Fill FIFO (DEPTH=2) with a3=3 and a3=4 while p_we=1 → m_ready=0. Third m_valid held. After two free cycles, $3 then $4 are written, m_ready rises, and the third result is accepted.
4. FIFO holds a3=7. P writes a3=7 → entry squashed; squash_cnt=1; busy[7]=0 next cycle; no later GRF write to $7 from M.
5. M push with a3=0 → accepted, grf_we never asserted for it, busy stays 0.
6. Two entries buffered; assert reset for one cycle → FIFO empty, busy=0, grf_we=0, no stale writes after reset deasserts.
